// File: rtl/alu_pkg.sv
// Shared constants for the ALU share arbiter: MIPS opcode/func fields, ALU control, FSM states.
// No logic here; latency and backpressure live in the arbiter.
package alu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [5:0]  func;
      logic [31:0] a;
      logic [31:0] b;
   } alu_op_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational MIPS ALU: decodes opcode/func to an ALU control and computes result and zero flag.
// Zero latency, no flow control; the arbiter registers its outputs.
module alu_exec_unit
   import alu_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  func,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero
);

   alu_ctrl_t ctrl;

   // Loads/stores compute an address (ADD), branches compare (SUB); anything unknown falls back to ADD.
   always_comb begin
      ctrl = ALU_ADD;
      if (opcode == OP_RTYPE) begin
         case (func)
            FN_ADD:  ctrl = ALU_ADD;
            FN_SUB:  ctrl = ALU_SUB;
            FN_AND:  ctrl = ALU_AND;
            FN_OR:   ctrl = ALU_OR;
            FN_NOR:  ctrl = ALU_NOR;
            FN_SLT:  ctrl = ALU_SLT;
            default: ctrl = ALU_ADD;
         endcase
      end else if (opcode == OP_BEQ) begin
         ctrl = ALU_SUB;
      end
   end

   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_SLT: result = (a < b) ? 32'h1 : 32'h0;
         default: result = a + b;
      endcase
   end

   assign zero = (result == 32'h0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters; IDLE->EXEC->RESP, response valid two cycles after accept.
// Backpressure: RESP holds until the granted rsp_ready, and both req_ready stay low outside IDLE.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int RR_INIT = 0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [5:0]  req0_opcode,
   input  logic [5:0]  req0_func,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [5:0]  req1_opcode,
   input  logic [5:0]  req1_func,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_zero,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_zero
);

   localparam logic RR_INIT_BIT = (RR_INIT != 0);

   arb_state_t  state_q, state_d;
   alu_op_t     op_q, op_sel;
   logic        gnt_q, gnt_idx;
   logic        rr_q;
   logic [31:0] result_q, exec_result;
   logic        zero_q, exec_zero;
   logic        in_idle, hs, rsp_done;

   // Single valid wins outright; a tie goes to the round-robin pointer.
   always_comb begin
      gnt_idx = req1_valid;
      if (req0_valid && req1_valid) begin
         gnt_idx = rr_q;
      end
   end

   assign in_idle    = (state_q == ST_IDLE) && rst_n;
   assign req0_ready = in_idle && req0_valid && !gnt_idx;
   assign req1_ready = in_idle && req1_valid && gnt_idx;
   assign hs         = req0_ready || req1_ready;
   assign op_sel     = gnt_idx ? {req1_opcode, req1_func, req1_a, req1_b}
                               : {req0_opcode, req0_func, req0_a, req0_b};
   assign rsp_done   = (state_q == ST_RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (hs) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         gnt_q    <= 1'b0;
         rr_q     <= RR_INIT_BIT;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && hs) begin
            op_q  <= op_sel;
            gnt_q <= gnt_idx;
         end
         if (state_q == ST_EXEC) begin
            result_q <= exec_result;
            zero_q   <= exec_zero;
         end
         if (rsp_done) begin
            rr_q <= ~gnt_q;
         end
      end
   end

   alu_exec_unit u_exec (
      .opcode (op_q.opcode),
      .func   (op_q.func),
      .a      (op_q.a),
      .b      (op_q.b),
      .result (exec_result),
      .zero   (exec_zero)
   );

   assign rsp0_valid  = (state_q == ST_RESP) && !gnt_q;
   assign rsp1_valid  = (state_q == ST_RESP) && gnt_q;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;
   assign rsp0_zero   = zero_q;
   assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: queue-fed requesters, transaction-level arbitration/ALU model checked every cycle.
// Directed vector table, multi-cycle corner sequences, then randomized traffic with random response backpressure.
module tb_alu_share_arbiter;

   localparam int RR_INIT = 0;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        zero;
      int          hold;
   } done_t;

   typedef struct {
      int          idx;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [5:0]  req_opcode [2];
   logic [5:0]  req_func   [2];
   logic [31:0] req_a      [2];
   logic [31:0] req_b      [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_result [2];
   logic        rsp_zero   [2];

   always #5 clk = ~clk;

   alu_share_arbiter #(.RR_INIT(RR_INIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req_valid[0]),
      .req0_ready  (req_ready[0]),
      .req0_opcode (req_opcode[0]),
      .req0_func   (req_func[0]),
      .req0_a      (req_a[0]),
      .req0_b      (req_b[0]),
      .req1_valid  (req_valid[1]),
      .req1_ready  (req_ready[1]),
      .req1_opcode (req_opcode[1]),
      .req1_func   (req_func[1]),
      .req1_a      (req_a[1]),
      .req1_b      (req_b[1]),
      .rsp0_valid  (rsp_valid[0]),
      .rsp0_ready  (rsp_ready[0]),
      .rsp0_result (rsp_result[0]),
      .rsp0_zero   (rsp_zero[0]),
      .rsp1_valid  (rsp_valid[1]),
      .rsp1_ready  (rsp_ready[1]),
      .rsp1_result (rsp_result[1]),
      .rsp1_zero   (rsp_zero[1])
   );

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          busy = 0;
   int          bidx = 0;
   int          acc_cyc = 0;
   int          ptr = RR_INIT;
   int          hold = 0;
   logic [31:0] exp_res;
   logic        exp_zero;
   bit          hs [2];
   int          stall_left [2];
   bit          rand_rdy = 0;
   op_t         q0 [$];
   op_t         q1 [$];
   done_t       done_log [$];
   int          grant_log [$];
   int          acc_log [$];
   logic [5:0]  op_pick [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h00};
   logic [5:0]  fn_pick [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

   function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference ALU from the instruction-set rules, using 64-bit arithmetic reduced modulo 2^32.
   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
      longint unsigned m  = 64'h1_0000_0000;
      longint unsigned la = 64'(a);
      longint unsigned lb = 64'(b);
      if (op == 6'h04) return 32'((la + m - lb) % m);
      if (op != 6'h00) return 32'((la + lb) % m);
      case (fn)
         6'h22:   return 32'((la + m - lb) % m);
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h27:   return ~(a | b);
         6'h2A:   return (la < lb) ? 32'd1 : 32'd0;
         default: return 32'((la + lb) % m);
      endcase
   endfunction

   function automatic op_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b);
      op_t o;
      o.op = op; o.fn = fn; o.a = a; o.b = b;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.op = ($urandom_range(0, 5) == 5) ? 6'($urandom) : op_pick[$urandom_range(0, 4)];
      o.fn = ($urandom_range(0, 6) == 6) ? 6'($urandom) : fn_pick[$urandom_range(0, 5)];
      o.a  = $urandom;
      o.b  = ($urandom_range(0, 5) == 0) ? o.a : $urandom;
      return o;
   endfunction

   // Transaction-level observation at the falling edge.
   task automatic monitor();
      int   g;
      logic e;
      done_t d;
      cyc++;
      hs[0] = req_valid[0] && req_ready[0];
      hs[1] = req_valid[1] && req_ready[1];
      for (int i = 0; i < 2; i++) begin
         if (rsp_valid[i] && stall_left[i] > 0) stall_left[i]--;
      end
      check("ready_both", {31'd0, req_ready[0] & req_ready[1]}, 32'd0);
      if (busy) begin
         check("ready_busy", {30'd0, req_ready[1], req_ready[0]}, 32'd0);
         for (int i = 0; i < 2; i++) begin
            e = (i == bidx) && (cyc - acc_cyc >= 2);
            check("rsp_valid", {31'd0, rsp_valid[i]}, {31'd0, e});
         end
         if (rsp_valid[bidx] && (cyc - acc_cyc >= 2)) begin
            check("rsp_result", rsp_result[bidx], exp_res);
            check("rsp_zero", {31'd0, rsp_zero[bidx]}, {31'd0, exp_zero});
            hold++;
            if (rsp_ready[bidx]) begin
               d.idx = bidx; d.res = rsp_result[bidx]; d.zero = rsp_zero[bidx]; d.hold = hold;
               done_log.push_back(d);
               busy = 0;
               ptr = 1 - bidx;
            end
         end
      end else begin
         check("rsp_idle", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
         if (req_valid[0] || req_valid[1]) begin
            g = (req_valid[0] && req_valid[1]) ? ptr : (req_valid[1] ? 1 : 0);
            check("grant", {30'd0, req_ready[1], req_ready[0]}, (g == 1) ? 32'd2 : 32'd1);
            if (req_ready[g]) begin
               busy = 1; bidx = g; acc_cyc = cyc; hold = 0;
               exp_res  = ref_alu(req_opcode[g], req_func[g], req_a[g], req_b[g]);
               exp_zero = (exp_res == 32'd0);
               grant_log.push_back(g);
               acc_log.push_back(cyc);
            end
         end else begin
            check("ready_noreq", {30'd0, req_ready[1], req_ready[0]}, 32'd0);
         end
      end
   endtask

   task automatic drive();
      op_t o;
      if (hs[0]) o = q0.pop_front();
      if (hs[1]) o = q1.pop_front();
      hs[0] = 0; hs[1] = 0;
      req_valid[0] = (q0.size() > 0);
      if (q0.size() > 0) begin
         o = q0[0];
         req_opcode[0] = o.op; req_func[0] = o.fn; req_a[0] = o.a; req_b[0] = o.b;
      end
      req_valid[1] = (q1.size() > 0);
      if (q1.size() > 0) begin
         o = q1[0];
         req_opcode[1] = o.op; req_func[1] = o.fn; req_a[1] = o.a; req_b[1] = o.b;
      end
      for (int i = 0; i < 2; i++) begin
         if (stall_left[i] > 0)  rsp_ready[i] = 1'b0;
         else if (rand_rdy)      rsp_ready[i] = 1'($urandom_range(0, 1));
         else                    rsp_ready[i] = 1'b1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) monitor();
      else begin hs[0] = 0; hs[1] = 0; end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", {31'd0, (busy || q0.size() > 0 || q1.size() > 0)}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [14];
      int   db, gb, ab;
      vecs[0]  = '{0, 6'h00, 6'h20, 32'h0000_2222, 32'h0000_1111, 32'h0000_3333, 1'b0};
      vecs[1]  = '{0, 6'h00, 6'h22, 32'h0000_5555, 32'h0000_5555, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1, 6'h04, 6'h00, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1};
      vecs[3]  = '{1, 6'h3F, 6'h20, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
      vecs[4]  = '{0, 6'h00, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
      vecs[5]  = '{1, 6'h00, 6'h25, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
      vecs[6]  = '{0, 6'h00, 6'h27, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1, 6'h00, 6'h2A, 32'h0000_1111, 32'h0000_2222, 32'h0000_0001, 1'b0};
      vecs[8]  = '{0, 6'h00, 6'h2A, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1, 6'h23, 6'h11, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0};
      vecs[10] = '{0, 6'h2B, 6'h00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0};
      vecs[11] = '{1, 6'h00, 6'h03, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 1'b0};
      vecs[12] = '{0, 6'h00, 6'h22, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
      vecs[13] = '{1, 6'h04, 6'h2A, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};

      rst_n = 1'b0;
      stall_left[0] = 0; stall_left[1] = 0;
      hs[0] = 0; hs[1] = 0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b1; req_opcode[i] = '0; req_func[i] = '0; req_a[i] = '0; req_b[i] = '0;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", {30'd0, req_ready[1], req_ready[0]}, 32'd0);
      check("reset_rsp_valid", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
      check("reset_result", rsp_result[0], 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();

      // Simultaneous requests straight after reset: pointer favours requester 0.
      db = done_log.size();
      q0.push_back(mk(6'h00, 6'h22, 32'h5555, 32'h5555));
      q1.push_back(mk(6'h04, 6'h00, 32'd7, 32'd7));
      drive();
      run_idle(40);
      check("both_count", 32'(done_log.size() - db), 32'd2);
      if (done_log.size() >= db + 2) begin
         check("both_first_idx", 32'(done_log[db].idx), 32'd0);
         check("both_first_zero", {31'd0, done_log[db].zero}, 32'd1);
         check("both_second_idx", 32'(done_log[db + 1].idx), 32'd1);
         check("both_second_res", done_log[db + 1].res, 32'd0);
      end

      // Both held valid across four operations: strict alternation, three cycles each.
      gb = grant_log.size();
      ab = acc_log.size();
      for (int k = 0; k < 2; k++) begin
         q0.push_back(mk(6'h00, 6'h20, 32'(k), 32'd1));
         q1.push_back(mk(6'h00, 6'h25, 32'(k), 32'd2));
      end
      drive();
      run_idle(60);
      check("rr_count", 32'(grant_log.size() - gb), 32'd4);
      if (grant_log.size() >= gb + 4) begin
         for (int k = 0; k < 4; k++) check("rr_order", 32'(grant_log[gb + k]), 32'(k % 2));
         for (int k = 0; k < 3; k++) check("rr_spacing", 32'(acc_log[ab + k + 1] - acc_log[ab + k]), 32'd3);
      end

      for (int v = 0; v < 14; v++) begin
         db = done_log.size();
         if (vecs[v].idx == 0) q0.push_back(mk(vecs[v].op, vecs[v].fn, vecs[v].a, vecs[v].b));
         else                  q1.push_back(mk(vecs[v].op, vecs[v].fn, vecs[v].a, vecs[v].b));
         drive();
         run_idle(30);
         check("vec_count", 32'(done_log.size() - db), 32'd1);
         if (done_log.size() > db) begin
            check("vec_idx", 32'(done_log[db].idx), 32'(vecs[v].idx));
            check("vec_result", done_log[db].res, vecs[v].exp_res);
            check("vec_zero", {31'd0, done_log[db].zero}, {31'd0, vecs[v].exp_zero});
         end
      end

      // Requester 1 stalls its response for five cycles while requester 0 waits.
      db = done_log.size();
      stall_left[1] = 5;
      q1.push_back(mk(6'h00, 6'h2A, 32'h1111, 32'h2222));
      drive();
      step();
      step();
      q0.push_back(mk(6'h00, 6'h20, 32'd1, 32'd2));
      drive();
      run_idle(60);
      check("stall_count", 32'(done_log.size() - db), 32'd2);
      if (done_log.size() >= db + 2) begin
         check("stall_idx", 32'(done_log[db].idx), 32'd1);
         check("stall_result", done_log[db].res, 32'd1);
         check("stall_hold", 32'(done_log[db].hold), 32'd6);
         check("stall_next_idx", 32'(done_log[db + 1].idx), 32'd0);
         check("stall_next_res", done_log[db + 1].res, 32'd3);
      end

      // Serve req0 so the pointer moves to 1, then kill a transaction during EXEC.
      q0.push_back(mk(6'h00, 6'h20, 32'd4, 32'd4));
      drive();
      run_idle(30);
      q0.push_back(mk(6'h00, 6'h20, 32'd9, 32'd9));
      drive();
      for (int n = 0; n < 20 && !(busy && cyc == acc_cyc); n++) step();
      check("exec_reached", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      busy = 0;
      ptr = RR_INIT;
      q0.push_back(mk(6'h00, 6'h20, 32'd10, 32'd1));
      q1.push_back(mk(6'h00, 6'h20, 32'd20, 32'd2));
      drive();
      @(negedge clk);
      check("midrst_ready", {30'd0, req_ready[1], req_ready[0]}, 32'd0);
      check("midrst_rsp_valid", {30'd0, rsp_valid[1], rsp_valid[0]}, 32'd0);
      check("midrst_result", rsp_result[0], 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      db = done_log.size();
      gb = grant_log.size();
      run_idle(40);
      check("postrst_count", 32'(done_log.size() - db), 32'd2);
      if (grant_log.size() >= gb + 2) begin
         check("postrst_first", 32'(grant_log[gb]), 32'(RR_INIT));
         check("postrst_second", 32'(grant_log[gb + 1]), 32'(1 - RR_INIT));
      end
      if (done_log.size() >= db + 2) begin
         check("postrst_res0", done_log[db].res, 32'd11);
         check("postrst_res1", done_log[db + 1].res, 32'd22);
      end

      // Random traffic with random response backpressure.
      db = done_log.size();
      rand_rdy = 1;
      for (int n = 0; n < 400; n++) begin
         if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
         if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
         step();
      end
      run_idle(400);
      rand_rdy = 0;
      check("rand_progress", {31'd0, (done_log.size() - db) > 20}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: RR_INIT, default 0, index of the requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_opcode  input  6  MIPS opcode field.
REQ-007 reqN_func  input  6  MIPS function field.
REQ-008 reqN_a, reqN_b  input  32 each  operands.
REQ-009 rspN_valid  output  1  result for requester N available.
REQ-010 rspN_ready  input  1  requester N consumes result.
REQ-011 rspN_result  output  32  registered ALU result.
REQ-012 rspN_zero  output  1  registered zero flag (result == 0).

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-014 In IDLE, reqN_ready SHALL be asserted combinationally only for the granted requester; never both.
REQ-015 Grant: if one valid, that one; if both valid, the requester indicated by the priority pointer.
REQ-016 On handshake (valid & ready) in IDLE: opcode, func, a, b and grant index SHALL be registered; IDLE -> EXEC.
REQ-017 In EXEC the shared exec unit SHALL compute from registered operands; result and zero registered; EXEC -> RESP.
REQ-018 In RESP, rspN_valid SHALL be asserted only for the granted requester and held, with stable result/zero, until rspN_ready; then RESP -> IDLE.
REQ-019 Latency: handshake at edge T, rspN_valid high from edge T+2; minimum 3 cycles per operation when rspN_ready is held high.
REQ-020 On RESP exit the priority pointer SHALL point to the requester not just served (round-robin).
REQ-021 Decode: opcode 0x00 with func 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; opcode 0x23/0x2B ADD; 0x04 SUB; any other opcode or func SHALL execute ADD.
REQ-022 Arithmetic SHALL be 32-bit modulo 2^32 with carries discarded; SLT SHALL be unsigned compare yielding 32'h1 or 32'h0.
REQ-023 While not in IDLE, both reqN_ready SHALL be 0 regardless of reqN_valid.
REQ-024 rspN_ready low in RESP SHALL stall indefinitely; the other requester's pending request waits.
REQ-025 rspN_ready asserted outside RESP or for the non-granted requester SHALL have no effect.
REQ-026 A request arriving on the same edge RESP exits SHALL be arbitrated in the following IDLE cycle with the updated pointer.

Reset
REQ-027 On rst_n low: state IDLE, pointer RR_INIT, all registered operands/results 0, rspN_valid 0, reqN_ready 0 during reset.
REQ-028 Reset mid-operation SHALL discard the in-flight transaction; no response is produced for it.

Structure
REQ-029 Package alu_pkg SHALL hold opcode/func constants, the 3-bit ALU control encoding (ADD 0, SUB 1, AND 2, OR 3, NOR 4, SLT 5) and the FSM state enum.
REQ-030 One combinational sub-module alu_exec_unit (opcode, func, a, b -> result, zero) SHALL contain decode and compute; the arbiter instantiates it once.

Verification
REQ-031 Req0 only: opcode 0x00, func 0x20, a=0x2222, b=0x1111, rsp0_ready=1 -> rsp0_valid at T+2, result 0x3333, zero 0.
REQ-032 Both valid same cycle after reset (RR_INIT=0): req0 SUB 0x5555-0x5555, req1 opcode 0x04 a=b=7 -> req0 served first (result 0, zero 1), then req1 (result 0, zero 1); ready never both high.
REQ-033 Both held valid for 4 ops -> grant order 0,1,0,1.
REQ-034 Req1 SLT a=0x1111, b=0x2222, rsp1_ready low 5 cycles -> rsp1_valid held, result 0x1 stable, req0 ready low throughout.
REQ-035 Unknown opcode 0x3F, a=0xFFFFFFFF, b=1 -> ADD, result 0x0, zero 1.
REQ-036 rst_n pulsed low during EXEC -> no rsp_valid for that op, pointer returns to RR_INIT, next request served normally.
